avalon_ram_model: RTL and testbench
===================================

// Module: avalon_ram_model
// PURPOSE
//  Parametrised Avalon-MM slave memory model for CPU testbenches. Two mapped regions: boot/instruction at
//  INSTR_BASE, data at DATA_BASE. Configurable fixed or pseudo-random wait states.
//  Sits between the CPU bus master and the bench; probe/error/count outputs are for bench checking only.
// PARAMETERS
//  RAM_INIT_FILE  ""            hex file; $readmemh into instruction region word 0 upward at time 0
//  INSTR_BASE     32'hBFC00000  byte base of instruction region
//  INSTR_WORDS    1024          instruction region depth, 32-bit words
//  DATA_BASE      32'h00000000  byte base of data region
//  DATA_WORDS     1024          data region depth, 32-bit words
//  LATENCY        1             wait cycles per transfer, >=1 (max when RANDOM_WAIT=1)
//  RANDOM_WAIT    0             1: per-transfer latency drawn from LFSR, range 1..LATENCY
//  PROBE_ADDR     32'h00000000  byte address mirrored on probe_data
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   synchronous, active-high
//  address       in   32  byte address, must be word aligned
//  read          in   1   read request, held until waitrequest low
//  write         in   1   write request, held until waitrequest low
//  writedata     in   32  write data
//  byteenable    in   4   active-high lane enables; bit i -> writedata[8i+7:8i]
//  waitrequest   out  1   stall; transfer completes in the cycle it is low with read|write high
//  readdata      out  32  read data, valid in completing cycle
//  bus_error     out  1   sticky error flag
//  access_count  out  32  completed transfers (reads+writes, including errored ones)
//  probe_data    out  32  combinational copy of word at PROBE_ADDR (0 if unmapped)
// BEHAVIOUR
//  Reset: state IDLE, readdata=0, bus_error=0, access_count=0, LFSR=8'hA5. Memory contents not reset.
//  waitrequest forced 1 while reset high.
//  Mapping: hit if base <= address < base+4*WORDS; word index = (address-base)>>2.
//  Regions are disjoint; overlapping parameters are illegal.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: waitrequest = read|write (combinational). On read|write: capture address/op/writedata/byteenable;
//    cnt = latency-1; go BUSY.
//   BUSY: waitrequest=1. cnt!=0: decrement. cnt==0: perform access, go DONE.
//    Read: readdata <= word. Write: update only enabled byte lanes.
//   DONE: waitrequest=0, readdata held; access_count++; go IDLE.
//  Latency: request seen in cycle 0 -> waitrequest low in cycle latency+1 (LATENCY=1: completes cycle 2).
//  Back-to-back: next request is recognised in IDLE, one cycle after DONE.
//  RANDOM_WAIT=1: 8-bit Fibonacci LFSR, taps 8,6,5,4, steps every cycle out of reset.
//   latency = (lfsr % LATENCY) + 1, sampled on IDLE->BUSY.
//  Errors (set bus_error, which stays 1 until reset):
//   - unmapped address: read returns 0, write dropped; transfer still completes normally.
//   - address[1:0]!=0: treated as unmapped.
//   - read&write both high in IDLE: no access, readdata=0, completes normally.
//   - read|write dropped while BUSY: abort, no memory update, no count, return to IDLE next cycle.
//  byteenable=4'b0000 write: legal, completes, memory unchanged.
//  readdata bus-visible only in DONE; the value is unspecified at other times (model holds last value).
//  access_count wraps 32'hFFFFFFFF -> 0.
//  Reset mid-transfer: abort, no memory update, IDLE next cycle after reset deasserts.
// TESTING
//  1. reset; read 0xBFC00000 with init word0=32'h24020005, LATENCY=1
//     -> waitrequest 1,1,0; readdata=32'h24020005 in cycle 2; access_count=1.
//  2. write 0x00000010 data 32'hAABBCCDD be=4'b1111, then be=4'b0101 data 32'h11223344, read back
//     -> 32'hAA22CC44.
//  3. read 0x00100000 (unmapped) and misaligned read 0x00000002
//     -> readdata=0, both complete, bus_error=1 and stays 1.
//  4. LATENCY=4 RANDOM_WAIT=1, 50 back-to-back reads
//     -> each stall 1..4 cycles, all data correct, access_count=50.
//  5. write started, reset asserted in BUSY -> target word unchanged, waitrequest=1 during reset,
//     next read returns the old value.
//  6. write 32'hCAFEF00D to PROBE_ADDR -> probe_data=32'hCAFEF00D in the cycle after DONE.

Source files
------------

// File: rtl/avalon_ram_model.sv
// Avalon-MM slave memory model with an instruction region and a data region,
// fixed or LFSR-driven wait states, sticky error flag, transfer counter and probe.
module avalon_ram_model #(
  parameter string       RAM_INIT_FILE = "",
  parameter logic [31:0] INSTR_BASE    = 32'hBFC00000,
  parameter int unsigned INSTR_WORDS   = 1024,
  parameter logic [31:0] DATA_BASE     = 32'h00000000,
  parameter int unsigned DATA_WORDS    = 1024,
  parameter int unsigned LATENCY       = 1,
  parameter int unsigned RANDOM_WAIT   = 0,
  parameter logic [31:0] PROBE_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        bus_error,
  output logic [31:0] access_count,
  output logic [31:0] probe_data
);

  localparam int unsigned IAW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int unsigned DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [31:0] LAT = 32'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Word-aligned address inside [base, base + 4*words); misaligned counts as a miss.
  function automatic logic region_hit(input logic [31:0] a, input logic [31:0] base,
                                      input int unsigned words);
    logic [32:0] hi;
    hi = 33'(base) + (33'(words) << 2);
    return (33'(a) >= 33'(base)) && (33'(a) < hi) && (a[1:0] == 2'b00);
  endfunction

  localparam logic           PROBE_IHIT = region_hit(PROBE_ADDR, INSTR_BASE, INSTR_WORDS);
  localparam logic           PROBE_DHIT = region_hit(PROBE_ADDR, DATA_BASE, DATA_WORDS);
  localparam logic [IAW-1:0] PROBE_IIDX = IAW'((PROBE_ADDR - INSTR_BASE) >> 2);
  localparam logic [DAW-1:0] PROBE_DIDX = DAW'((PROBE_ADDR - DATA_BASE) >> 2);

  logic [31:0] instr_mem [INSTR_WORDS];
  logic [31:0] data_mem  [DATA_WORDS];

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] readdata_q, readdata_d;
  logic        bus_error_q, bus_error_d;
  logic [31:0] access_count_q, access_count_d;
  logic [7:0]  lfsr_q, lfsr_d;

  logic           ihit, dhit, mem_we;
  logic [IAW-1:0] iidx;
  logic [DAW-1:0] didx;
  logic [31:0]    mem_word;

  // Decode the captured address into region hit, word index and stored word.
  always_comb begin
    ihit     = region_hit(addr_q, INSTR_BASE, INSTR_WORDS);
    dhit     = region_hit(addr_q, DATA_BASE, DATA_WORDS);
    iidx     = IAW'((addr_q - INSTR_BASE) >> 2);
    didx     = DAW'((addr_q - DATA_BASE) >> 2);
    mem_word = '0;
    if (ihit)      mem_word = instr_mem[iidx];
    else if (dhit) mem_word = data_mem[didx];
  end

  // Next-state, capture, access and bus-facing waitrequest.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    cnt_d          = cnt_q;
    readdata_d     = readdata_q;
    bus_error_d    = bus_error_q;
    access_count_d = access_count_q;
    lfsr_d         = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    waitrequest    = 1'b1;
    mem_we         = 1'b0;
    case (state_q)
      IDLE: begin
        waitrequest = read | write;
        if (read | write) begin
          addr_d  = address;
          wdata_d = writedata;
          be_d    = byteenable;
          rd_d    = read;
          wr_d    = write;
          cnt_d   = (RANDOM_WAIT != 0) ? (32'(lfsr_q) % LAT) : (LAT - 32'd1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!(read | write)) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          state_d = DONE;
          if (rd_q && wr_q) begin
            readdata_d  = '0;
            bus_error_d = 1'b1;
          end else if (!(ihit || dhit)) begin
            bus_error_d = 1'b1;
            if (rd_q) readdata_d = '0;
          end else if (rd_q) begin
            readdata_d = mem_word;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      DONE: begin
        waitrequest    = 1'b0;
        access_count_d = access_count_q + 32'd1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      waitrequest = 1'b1;
      mem_we      = 1'b0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      cnt_q          <= '0;
      readdata_q     <= '0;
      bus_error_q    <= 1'b0;
      access_count_q <= '0;
      lfsr_q         <= 8'hA5;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      cnt_q          <= cnt_d;
      readdata_q     <= readdata_d;
      bus_error_q    <= bus_error_d;
      access_count_q <= access_count_d;
      lfsr_q         <= lfsr_d;
    end
  end

  // Byte-lane writes into whichever region the captured address hits.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (mem_we && ihit && be_q[i]) instr_mem[iidx][8*i +: 8] <= wdata_q[8*i +: 8];
      if (mem_we && dhit && be_q[i]) data_mem[didx][8*i +: 8]  <= wdata_q[8*i +: 8];
    end
  end

  // Probe mirrors the stored word at a fixed address.
  always_comb begin
    probe_data = '0;
    if (PROBE_IHIT)      probe_data = instr_mem[PROBE_IIDX];
    else if (PROBE_DHIT) probe_data = data_mem[PROBE_DIDX];
  end

  assign readdata     = readdata_q;
  assign bus_error    = bus_error_q;
  assign access_count = access_count_q;

endmodule

// File: tb/tb_avalon_ram_model.sv
// Directed bench: DUT a uses fixed single-cycle latency, DUT b random 1..4 waits.
module tb_avalon_ram_model;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  ben = '0;

    logic        wreq_a, wreq_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b, cnt_a, cnt_b, probe_a, probe_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    avalon_ram_model #(
        .LATENCY     (1),
        .RANDOM_WAIT (0),
        .PROBE_ADDR  (32'h00000040)
    ) dut_a (
        .clk(clk), .reset(reset), .address(addr), .read(rd & ~sel), .write(wr & ~sel),
        .writedata(wdata), .byteenable(ben), .waitrequest(wreq_a), .readdata(rdata_a),
        .bus_error(err_a), .access_count(cnt_a), .probe_data(probe_a)
    );

    avalon_ram_model #(
        .LATENCY     (4),
        .RANDOM_WAIT (1)
    ) dut_b (
        .clk(clk), .reset(reset), .address(addr), .read(rd & sel), .write(wr & sel),
        .writedata(wdata), .byteenable(ben), .waitrequest(wreq_b), .readdata(rdata_b),
        .bus_error(err_b), .access_count(cnt_b), .probe_data(probe_b)
    );

    wire        wreq_s  = sel ? wreq_b : wreq_a;
    wire [31:0] rdata_s = sel ? rdata_b : rdata_a;
    wire        err_s   = sel ? err_b : err_a;
    wire [31:0] cnt_s   = sel ? cnt_b : cnt_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at #1 after a rising edge; leaves the request asserted on return.
    task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] q, output int waits);
        rd = r; wr = w; addr = a; wdata = d; ben = be;
        waits = 0;
        q = '0;
        forever begin
            @(negedge clk);
            if (!wreq_s) begin
                q = rdata_s;
                break;
            end
            waits++;
            if (waits > 40) begin
                check("xfer_timeout", {31'b0, wreq_s}, 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] q;
    int          w;

    initial begin
        // Reset, with a request pending to show waitrequest is forced high.
        rd = 1'b1; addr = 32'hBFC00000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_waitreq", {31'b0, wreq_a}, 32'd1);
        rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_readdata", rdata_a, 32'd0);
        check("reset_err", {31'b0, err_a}, 32'd0);
        check("reset_count", cnt_a, 32'd0);
        check("idle_waitreq", {31'b0, wreq_a}, 32'd0);
        @(posedge clk); #1;

        // Boot word then single-latency read: waitrequest 1,1,0.
        xfer(0, 1, 32'hBFC00000, 32'h24020005, 4'hF, q, w);
        xfer(1, 0, 32'hBFC00000, 32'h0, 4'hF, q, w);
        check("boot_rd_data", q, 32'h24020005);
        check("boot_rd_waits", w, 32'd2);
        bus_idle();
        check("boot_count", cnt_a, 32'd2);

        // Byte-lane merge, then an all-lanes-off write that must change nothing.
        xfer(0, 1, 32'h00000010, 32'hAABBCCDD, 4'b1111, q, w);
        xfer(0, 1, 32'h00000010, 32'h11223344, 4'b0101, q, w);
        xfer(1, 0, 32'h00000010, 32'h0, 4'hF, q, w);
        check("lane_merge", q, 32'hAA22CC44);
        xfer(0, 1, 32'h00000010, 32'hFFFFFFFF, 4'b0000, q, w);
        xfer(1, 0, 32'h00000010, 32'h0, 4'hF, q, w);
        check("be_zero", q, 32'hAA22CC44);
        bus_idle();
        check("no_err_yet", {31'b0, err_a}, 32'd0);

        // Unmapped, misaligned and read+write collisions.
        xfer(1, 0, 32'h00100000, 32'h0, 4'hF, q, w);
        check("unmapped_rd", q, 32'd0);
        check("unmapped_err", {31'b0, err_a}, 32'd1);
        xfer(1, 0, 32'h00000002, 32'h0, 4'hF, q, w);
        check("misalign_rd", q, 32'd0);
        xfer(1, 1, 32'h00000010, 32'h0, 4'hF, q, w);
        check("rdwr_rd", q, 32'd0);
        bus_idle();
        check("err_sticky", {31'b0, err_a}, 32'd1);
        check("count_after_err", cnt_a, 32'd10);

        // Write dropped while BUSY aborts without update or count.
        xfer(0, 1, 32'h00000020, 32'h00000055, 4'hF, q, w);
        rd = 1'b0; wr = 1'b1; addr = 32'h00000020; wdata = 32'h00000099;
        @(posedge clk); #1;
        wr = 1'b0;
        @(posedge clk); #1;
        xfer(1, 0, 32'h00000020, 32'h0, 4'hF, q, w);
        check("abort_keep", q, 32'h00000055);
        bus_idle();
        check("abort_count", cnt_a, 32'd12);

        // Probe follows the stored word.
        xfer(0, 1, 32'h00000040, 32'hCAFEF00D, 4'hF, q, w);
        bus_idle();
        check("probe", probe_a, 32'hCAFEF00D);
        check("probe_count", cnt_a, 32'd13);

        // Random wait states on dut b, back-to-back reads.
        sel = 1'b1;
        for (int k = 0; k < 8; k++)
            xfer(0, 1, 32'(k * 4), 32'h10000000 + 32'(k) * 32'h0101, 4'hF, q, w);
        for (int i = 0; i < 50; i++) begin
            xfer(1, 0, 32'((i % 8) * 4), 32'h0, 4'hF, q, w);
            check("rand_data", q, 32'h10000000 + 32'(i % 8) * 32'h0101);
            check("rand_stall", {31'b0, (w >= 2 && w <= 5)}, 32'd1);
        end
        bus_idle();
        check("rand_count", cnt_b, 32'd58);
        check("rand_no_err", {31'b0, err_b}, 32'd0);
        sel = 1'b0;

        // Reset while a write is BUSY leaves memory untouched.
        rd = 1'b0; wr = 1'b1; addr = 32'h00000020; wdata = 32'hDEADBEEF; ben = 4'hF;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy_waitreq", {31'b0, wreq_a}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("rst_busy_count", cnt_s, 32'd0);
        check("rst_busy_err", {31'b0, err_s}, 32'd0);
        @(posedge clk); #1;
        xfer(1, 0, 32'h00000020, 32'h0, 4'hF, q, w);
        check("rst_busy_keep", q, 32'h00000055);
        bus_idle();
        check("rst_busy_count2", cnt_a, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
